codec_i2c_queue_regs: RTL and testbench
=======================================

// Module: codec_i2c_queue_regs
// PURPOSE
//  Next-generation CODEC I2C register bank: replaces one-shot addr/wr_data/rd_data regs with a SW-fed command FIFO and a HW-fed response FIFO.
//  Sits between the AXI-lite slave decoder and the CODEC I2C controller; lets SW queue a whole init/config sequence without polling per access.
//  Adds sticky W1C status with maskable interrupt.
// PARAMETERS
//  DATA_W     16   I2C data width carried per command/response (1..31)
//  ADDR_W     8    I2C register-address width (1..32)
//  CMD_DEPTH  8    command FIFO entries (power of 2, 2..128)
//  RSP_DEPTH  4    response FIFO entries (power of 2, 2..128)
// PORTS
//  axi_clk          in   1       sole clock
//  axi_reset        in   1       async reset, active-low
//  data_in          in   32      SW write data
//  data_out         out  32      SW read data (combinational from reg_addr_rd)
//  reg_addr_wr      in   6       SW write word address
//  reg_addr_rd      in   6       SW read word address
//  data_wren        in   1       SW write strobe, one cycle per write
//  data_rden        in   1       SW read strobe, one cycle per read (pop side effect)
//  byte_enable      in   4       byte lanes for RW registers
//  cmd_valid        out  1       command head available to controller
//  cmd_ready        in   1       controller accepts head
//  cmd_rd           out  1       1=read, 0=write
//  cmd_addr         out  ADDR_W  I2C register address
//  cmd_wdata        out  DATA_W  I2C write data
//  rsp_valid        in   1       one-cycle pulse: read data returned
//  rsp_data         in   DATA_W  read data
//  missed_ack       in   1       one-cycle pulse: NACK on bus
//  controller_busy  in   1       level
//  codec_init_done  in   1       one-cycle pulse
//  controller_reset out  1       controller reset request
//  irq              out  1       |(sticky & IRQ_EN), registered
// BEHAVIOUR
//  Map (word addr): 0x00 CTRL, 0x01 STATUS, 0x02 CMD_ADDR, 0x03 CMD_PUSH, 0x04 RSP_POP, 0x05 IRQ_EN; other reads -> 32'hdeadbeef.
//  CTRL: [0] ENABLE RW rst 0; [1] CMD_FLUSH, [2] RSP_FLUSH write-1 pulse, read 0; [31] controller_reset: SW W1 sets, codec_init_done clears, clear wins if same cycle.
//  STATUS: [0] cmd_full [1] cmd_empty [2] rsp_full [3] rsp_empty [4] controller_busy (live);
//    sticky W1C [8] init_done [9] missed_ack [10] cmd_overflow [11] rsp_underflow [12] rsp_overflow;
//    [23:16] cmd level 0..CMD_DEPTH, [31:24] rsp level 0..RSP_DEPTH; unused bits 0. Set and W1C same cycle: set wins.
//  CMD_ADDR: RW staging, bits [ADDR_W-1:0], byte_enable honoured, rst 0. IRQ_EN: RW [12:8], byte_enable honoured, rst 0.
//  CMD_PUSH write (byte_enable ignored): push {rd=data_in[31], CMD_ADDR, data_in[DATA_W-1:0]}; reads of 0x03 return 0.
//  Push accepted if !full, or full with a pop in same cycle; otherwise dropped, cmd_overflow set, FIFO unchanged.
//  cmd_valid = !cmd_empty & ENABLE & !controller_reset; cmd_* driven from registered head; pop on cmd_valid & cmd_ready.
//  No bypass: push into empty FIFO -> cmd_valid rises next cycle. ENABLE=0 freezes queue, entries kept.
//  rsp_valid: push rsp_data; if full, drop and set rsp_overflow (no simultaneous-pop exception).
//  RSP_POP read: data_out = {32-DATA_W zeros, head}; pop when data_rden & reg_addr_rd==0x04.
//    Empty: data_out=32'hdeadbeef, rsp_underflow set, pointers unchanged. Pop of a full FIFO coinciding with rsp_valid: both occur.
//  FLUSH: pointers to empty next cycle; a handshake/push in the same cycle is discarded (flush wins); stickies unaffected.
//  Pointers: log2(DEPTH)+1 bits, wrap mod 2*DEPTH; full = MSBs differ & rest equal.
//  irq updated one cycle after sticky/IRQ_EN change.
//  Reset (async, mid-operation included): FIFOs empty, all regs 0, cmd_valid=0, controller_reset=0, irq=0; stored entries lost.
// TESTING
//  ENABLE=1, CMD_ADDR=0x1A, push 0x0000_00F5 and 0x8000_0000, cmd_ready=1 -> cmd_valid 2 cycles: (0,0x1A,0x00F5) then (1,0x1A,0).
//  ENABLE=0, push 9 entries (CMD_DEPTH=8) -> level 8, cmd_full=1, cmd_overflow=1, cmd_valid=0; write 0x400 to STATUS -> bit10 clears.
//  Full FIFO, ENABLE=1, cmd_ready=1, push same cycle -> accepted, level stays 8, no overflow.
//  rsp_valid x5 with 0x11..0x15 (RSP_DEPTH=4) -> pops return 0x11..0x14, 5th pop 0xdeadbeef + rsp_underflow; rsp_overflow=1.
//  IRQ_EN=0x200, missed_ack pulse -> irq=1 next cycle; W1C bit9 same cycle as new pulse -> bit stays set.
//  Write CTRL bit31 -> controller_reset=1, cmd_valid=0; codec_init_done pulse -> controller_reset=0, STATUS[8]=1; assert axi_reset mid-queue -> levels 0.

Source files
------------

// File: rtl/codec_i2c_queue_regs.sv
// CODEC I2C queued register bank.
// SW queues I2C commands (rd flag, register address, write data) into a command
// FIFO that the controller drains with a valid/ready handshake. Read data coming
// back from the controller fills a response FIFO that SW pops through RSP_POP.
// Sticky W1C status bits feed a maskable, registered interrupt.
module codec_i2c_queue_regs #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 8,
  parameter int CMD_DEPTH = 8,
  parameter int RSP_DEPTH = 4
) (
  input  logic              axi_clk,
  input  logic              axi_reset,
  input  logic [31:0]       data_in,
  output logic [31:0]       data_out,
  input  logic [5:0]        reg_addr_wr,
  input  logic [5:0]        reg_addr_rd,
  input  logic              data_wren,
  input  logic              data_rden,
  input  logic [3:0]        byte_enable,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_rd,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [DATA_W-1:0] cmd_wdata,
  input  logic              rsp_valid,
  input  logic [DATA_W-1:0] rsp_data,
  input  logic              missed_ack,
  input  logic              controller_busy,
  input  logic              codec_init_done,
  output logic              controller_reset,
  output logic              irq
);

  localparam int CMD_AW = $clog2(CMD_DEPTH);
  localparam int RSP_AW = $clog2(RSP_DEPTH);
  localparam int CMD_W  = 1 + ADDR_W + DATA_W;

  localparam logic [5:0]  A_CTRL     = 6'h00;
  localparam logic [5:0]  A_STATUS   = 6'h01;
  localparam logic [5:0]  A_CMD_ADDR = 6'h02;
  localparam logic [5:0]  A_CMD_PUSH = 6'h03;
  localparam logic [5:0]  A_RSP_POP  = 6'h04;
  localparam logic [5:0]  A_IRQ_EN   = 6'h05;
  localparam logic [31:0] BAD_READ   = 32'hDEAD_BEEF;

  // Storage and pointers (one extra MSB distinguishes full from empty)
  logic [CMD_W-1:0]  cmd_mem_r [CMD_DEPTH];
  logic [DATA_W-1:0] rsp_mem_r [RSP_DEPTH];
  logic [CMD_AW:0]   cmd_wptr_r, cmd_rptr_r;
  logic [RSP_AW:0]   rsp_wptr_r, rsp_rptr_r;

  // Control / status registers
  logic              enable_r;
  logic              ctrl_reset_r;
  logic [ADDR_W-1:0] cmd_addr_r;
  logic [4:0]        irq_en_r;
  logic [4:0]        sticky_r;
  logic              irq_r;

  // Decoded strobes
  logic wr_ctrl_s, wr_status_s, wr_cmd_addr_s, wr_push_s, wr_irq_en_s;
  logic cmd_flush_s, rsp_flush_s, pop_req_s;

  // FIFO status and handshakes
  logic [CMD_AW:0]   cmd_level_s;
  logic [RSP_AW:0]   rsp_level_s;
  logic              cmd_empty_s, cmd_full_s, rsp_empty_s, rsp_full_s;
  logic              cmd_valid_s, cmd_pop_s, cmd_push_s, cmd_ovf_s;
  logic              rsp_pop_s, rsp_push_s, rsp_ovf_s, rsp_udf_s;
  logic [CMD_W-1:0]  cmd_head_s, cmd_entry_s;
  logic [DATA_W-1:0] rsp_head_s;
  logic [31:0]       be_mask_s;
  logic [4:0]        sticky_set_s, w1c_s;
  logic              unused_s;

  assign wr_ctrl_s     = data_wren & (reg_addr_wr == A_CTRL);
  assign wr_status_s   = data_wren & (reg_addr_wr == A_STATUS);
  assign wr_cmd_addr_s = data_wren & (reg_addr_wr == A_CMD_ADDR);
  assign wr_push_s     = data_wren & (reg_addr_wr == A_CMD_PUSH);
  assign wr_irq_en_s   = data_wren & (reg_addr_wr == A_IRQ_EN);
  assign cmd_flush_s   = wr_ctrl_s & data_in[1];
  assign rsp_flush_s   = wr_ctrl_s & data_in[2];
  assign pop_req_s     = data_rden & (reg_addr_rd == A_RSP_POP);

  assign be_mask_s = {{8{byte_enable[3]}}, {8{byte_enable[2]}},
                      {8{byte_enable[1]}}, {8{byte_enable[0]}}};

  assign cmd_level_s = cmd_wptr_r - cmd_rptr_r;
  assign rsp_level_s = rsp_wptr_r - rsp_rptr_r;
  assign cmd_empty_s = (cmd_wptr_r == cmd_rptr_r);
  assign rsp_empty_s = (rsp_wptr_r == rsp_rptr_r);
  assign cmd_full_s  = (cmd_wptr_r[CMD_AW] != cmd_rptr_r[CMD_AW]) &&
                       (cmd_wptr_r[CMD_AW-1:0] == cmd_rptr_r[CMD_AW-1:0]);
  assign rsp_full_s  = (rsp_wptr_r[RSP_AW] != rsp_rptr_r[RSP_AW]) &&
                       (rsp_wptr_r[RSP_AW-1:0] == rsp_rptr_r[RSP_AW-1:0]);

  assign cmd_head_s  = cmd_mem_r[cmd_rptr_r[CMD_AW-1:0]];
  assign rsp_head_s  = rsp_mem_r[rsp_rptr_r[RSP_AW-1:0]];
  assign cmd_entry_s = {data_in[31], cmd_addr_r, data_in[DATA_W-1:0]};

  // Queue is frozen while disabled or while the controller is held in reset
  assign cmd_valid_s = ~cmd_empty_s & enable_r & ~ctrl_reset_r;
  assign cmd_pop_s   = cmd_valid_s & cmd_ready;
  // A push into a full FIFO is still legal when the head leaves the same cycle
  assign cmd_push_s  = wr_push_s & (~cmd_full_s | cmd_pop_s);
  assign cmd_ovf_s   = wr_push_s & cmd_full_s & ~cmd_pop_s;

  // Response side has no pop-makes-room exception: full always drops
  assign rsp_push_s  = rsp_valid & ~rsp_full_s;
  assign rsp_ovf_s   = rsp_valid & rsp_full_s;
  assign rsp_pop_s   = pop_req_s & ~rsp_empty_s;
  assign rsp_udf_s   = pop_req_s & rsp_empty_s;

  assign sticky_set_s = {rsp_ovf_s, rsp_udf_s, cmd_ovf_s, missed_ack, codec_init_done};

  assign cmd_valid        = cmd_valid_s;
  assign cmd_rd           = cmd_head_s[CMD_W-1];
  assign cmd_addr         = cmd_head_s[CMD_W-2 -: ADDR_W];
  assign cmd_wdata        = cmd_head_s[DATA_W-1:0];
  assign controller_reset = ctrl_reset_r;
  assign irq              = irq_r;

  // Data bits / lanes that are not used by every parameterisation
  assign unused_s = ^{data_in, be_mask_s};

  // W1C mask taken from the STATUS write data
  always_comb begin
    w1c_s = 5'b0;
    if (wr_status_s) begin
      w1c_s = data_in[12:8];
    end else begin
      w1c_s = 5'b0;
    end
  end

  // Command FIFO storage write (contents need no reset; pointers define validity)
  always_ff @(posedge axi_clk) begin
    if (cmd_push_s && !cmd_flush_s) begin
      cmd_mem_r[cmd_wptr_r[CMD_AW-1:0]] <= cmd_entry_s;
    end
  end

  // Response FIFO storage write
  always_ff @(posedge axi_clk) begin
    if (rsp_push_s && !rsp_flush_s) begin
      rsp_mem_r[rsp_wptr_r[RSP_AW-1:0]] <= rsp_data;
    end
  end

  // FIFO pointers; a flush overrides any push/pop in the same cycle
  always_ff @(posedge axi_clk or negedge axi_reset) begin
    if (!axi_reset) begin
      cmd_wptr_r <= '0;
      cmd_rptr_r <= '0;
      rsp_wptr_r <= '0;
      rsp_rptr_r <= '0;
    end else begin
      if (cmd_flush_s) begin
        cmd_wptr_r <= '0;
        cmd_rptr_r <= '0;
      end else begin
        if (cmd_push_s) cmd_wptr_r <= cmd_wptr_r + (CMD_AW+1)'(1);
        if (cmd_pop_s)  cmd_rptr_r <= cmd_rptr_r + (CMD_AW+1)'(1);
      end
      if (rsp_flush_s) begin
        rsp_wptr_r <= '0;
        rsp_rptr_r <= '0;
      end else begin
        if (rsp_push_s) rsp_wptr_r <= rsp_wptr_r + (RSP_AW+1)'(1);
        if (rsp_pop_s)  rsp_rptr_r <= rsp_rptr_r + (RSP_AW+1)'(1);
      end
    end
  end

  // SW-visible control registers; init_done beats a same-cycle controller_reset set
  always_ff @(posedge axi_clk or negedge axi_reset) begin
    if (!axi_reset) begin
      enable_r     <= 1'b0;
      ctrl_reset_r <= 1'b0;
      cmd_addr_r   <= '0;
      irq_en_r     <= 5'b0;
    end else begin
      if (wr_ctrl_s && byte_enable[0]) enable_r <= data_in[0];
      if (codec_init_done) begin
        ctrl_reset_r <= 1'b0;
      end else if (wr_ctrl_s && data_in[31]) begin
        ctrl_reset_r <= 1'b1;
      end
      if (wr_cmd_addr_s) begin
        cmd_addr_r <= (cmd_addr_r & ~be_mask_s[ADDR_W-1:0]) |
                      (data_in[ADDR_W-1:0] & be_mask_s[ADDR_W-1:0]);
      end
      if (wr_irq_en_s && byte_enable[1]) irq_en_r <= data_in[12:8];
    end
  end

  // Sticky status (set beats W1C) and the registered interrupt
  always_ff @(posedge axi_clk or negedge axi_reset) begin
    if (!axi_reset) begin
      sticky_r <= 5'b0;
      irq_r    <= 1'b0;
    end else begin
      sticky_r <= (sticky_r & ~w1c_s) | sticky_set_s;
      irq_r    <= |(sticky_r & irq_en_r);
    end
  end

  // Register read mux
  always_comb begin
    data_out = BAD_READ;
    case (reg_addr_rd)
      A_CTRL:     data_out = {ctrl_reset_r, 30'b0, enable_r};
      A_STATUS:   data_out = {8'(rsp_level_s), 8'(cmd_level_s), 3'b0, sticky_r, 3'b0,
                              controller_busy, rsp_empty_s, rsp_full_s,
                              cmd_empty_s, cmd_full_s};
      A_CMD_ADDR: data_out = 32'(cmd_addr_r);
      A_CMD_PUSH: data_out = 32'h0000_0000;
      A_RSP_POP:  data_out = rsp_empty_s ? BAD_READ : 32'(rsp_head_s);
      A_IRQ_EN:   data_out = {19'b0, irq_en_r, 8'b0};
      default:    data_out = BAD_READ;
    endcase
  end

endmodule

// File: tb/tb_codec_i2c_queue_regs.sv
// Directed bench for codec_i2c_queue_regs: register table plus hand sequences
// for the queue, response, interrupt, controller-reset and async-reset cases.
module tb_codec_i2c_queue_regs;

  logic        axi_clk = 1'b0;
  logic        axi_reset;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic [5:0]  reg_addr_wr, reg_addr_rd;
  logic        data_wren, data_rden;
  logic [3:0]  byte_enable;
  logic        cmd_valid, cmd_ready, cmd_rd;
  logic [7:0]  cmd_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        missed_ack, controller_busy, codec_init_done;
  logic        controller_reset, irq;

  int tests = 0;
  int fails = 0;

  always #5 axi_clk = ~axi_clk;

  codec_i2c_queue_regs #(.DATA_W(16), .ADDR_W(8), .CMD_DEPTH(8), .RSP_DEPTH(4)) dut (
    .axi_clk(axi_clk), .axi_reset(axi_reset),
    .data_in(data_in), .data_out(data_out),
    .reg_addr_wr(reg_addr_wr), .reg_addr_rd(reg_addr_rd),
    .data_wren(data_wren), .data_rden(data_rden), .byte_enable(byte_enable),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd(cmd_rd),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .missed_ack(missed_ack), .controller_busy(controller_busy),
    .codec_init_done(codec_init_done),
    .controller_reset(controller_reset), .irq(irq)
  );

  typedef struct {
    bit          is_wr;
    bit          pop;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  function automatic vec_t vw(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
    vec_t v;
    v.is_wr = 1'b1; v.pop = 1'b0; v.addr = a; v.data = d; v.be = be; v.exp = 32'h0;
    return v;
  endfunction

  function automatic vec_t vr(input logic [5:0] a, input bit pop, input logic [31:0] e);
    vec_t v;
    v.is_wr = 1'b0; v.pop = pop; v.addr = a; v.data = 32'h0; v.be = 4'h0; v.exp = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One SW write; starts just after a negedge, returns at the next negedge
  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
    reg_addr_wr = a; data_in = d; byte_enable = be; data_wren = 1'b1;
    @(negedge axi_clk);
    data_wren = 1'b0;
  endtask

  // SW read compared before the edge, optional pop strobe, returns at next negedge
  task automatic rd_chk(input string name, input logic [5:0] a, input bit pop, input logic [31:0] e);
    reg_addr_rd = a; data_rden = pop;
    #1;
    chk(name, data_out, e);
    @(negedge axi_clk);
    data_rden = 1'b0;
  endtask

  // Combinational read with no side effect and no clock advance
  task automatic peek(input string name, input logic [5:0] a, input logic [31:0] e);
    reg_addr_rd = a;
    #1;
    chk(name, data_out, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    axi_reset = 1'b0; data_in = 32'h0; reg_addr_wr = 6'h0; reg_addr_rd = 6'h0;
    data_wren = 1'b0; data_rden = 1'b0; byte_enable = 4'h0; cmd_ready = 1'b0;
    rsp_valid = 1'b0; rsp_data = 16'h0; missed_ack = 1'b0; controller_busy = 1'b0;
    codec_init_done = 1'b0;

    vecs[0]  = vr(6'h01, 1'b0, 32'h0000_000A);
    vecs[1]  = vr(6'h00, 1'b0, 32'h0000_0000);
    vecs[2]  = vr(6'h02, 1'b0, 32'h0000_0000);
    vecs[3]  = vr(6'h03, 1'b0, 32'h0000_0000);
    vecs[4]  = vr(6'h05, 1'b0, 32'h0000_0000);
    vecs[5]  = vr(6'h07, 1'b0, 32'hDEAD_BEEF);
    vecs[6]  = vr(6'h3F, 1'b0, 32'hDEAD_BEEF);
    vecs[7]  = vr(6'h04, 1'b0, 32'hDEAD_BEEF);
    vecs[8]  = vr(6'h01, 1'b0, 32'h0000_000A);
    vecs[9]  = vw(6'h02, 32'h1234_5678, 4'b0010);
    vecs[10] = vr(6'h02, 1'b0, 32'h0000_0000);
    vecs[11] = vw(6'h02, 32'hFFFF_FF1A, 4'b1111);
    vecs[12] = vr(6'h02, 1'b0, 32'h0000_001A);
    vecs[13] = vw(6'h02, 32'h0000_0055, 4'b1110);
    vecs[14] = vr(6'h02, 1'b0, 32'h0000_001A);
    vecs[15] = vw(6'h05, 32'hFFFF_FFFF, 4'b1101);
    vecs[16] = vr(6'h05, 1'b0, 32'h0000_0000);
    vecs[17] = vw(6'h05, 32'hFFFF_FFFF, 4'b1111);
    vecs[18] = vr(6'h05, 1'b0, 32'h0000_1F00);
    vecs[19] = vw(6'h05, 32'h0000_0000, 4'b1111);
    vecs[20] = vr(6'h05, 1'b0, 32'h0000_0000);
    vecs[21] = vw(6'h00, 32'h0000_0007, 4'b1111);
    vecs[22] = vr(6'h00, 1'b0, 32'h0000_0001);
    vecs[23] = vr(6'h01, 1'b0, 32'h0000_000A);

    repeat (2) @(negedge axi_clk);
    #1;
    chk("rst_cmd_valid", {31'b0, cmd_valid}, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    chk("rst_ctrl_reset", {31'b0, controller_reset}, 32'h0);
    @(negedge axi_clk);
    axi_reset = 1'b1;

    // Register table
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].is_wr) wr(vecs[i].addr, vecs[i].data, vecs[i].be);
      else rd_chk($sformatf("vec%0d", i), vecs[i].addr, vecs[i].pop, vecs[i].exp);
    end

    // Two commands drained back to back, no bypass on the first push
    cmd_ready = 1'b1;
    reg_addr_wr = 6'h03; data_in = 32'h0000_00F5; byte_enable = 4'hF; data_wren = 1'b1;
    #1;
    chk("no_bypass", {31'b0, cmd_valid}, 32'h0);
    @(negedge axi_clk);
    data_in = 32'h8000_0000;
    #1;
    chk("c1_valid", {31'b0, cmd_valid}, 32'h1);
    chk("c1_rd", {31'b0, cmd_rd}, 32'h0);
    chk("c1_addr", {24'b0, cmd_addr}, 32'h1A);
    chk("c1_wdata", {16'b0, cmd_wdata}, 32'h00F5);
    @(negedge axi_clk);
    data_wren = 1'b0;
    #1;
    chk("c2_valid", {31'b0, cmd_valid}, 32'h1);
    chk("c2_rd", {31'b0, cmd_rd}, 32'h1);
    chk("c2_addr", {24'b0, cmd_addr}, 32'h1A);
    chk("c2_wdata", {16'b0, cmd_wdata}, 32'h0000);
    @(negedge axi_clk);
    #1;
    chk("drained", {31'b0, cmd_valid}, 32'h0);

    // Disabled queue fills, ninth push overflows
    wr(6'h00, 32'h0, 4'hF);
    for (int i = 0; i < 9; i++) wr(6'h03, i, 4'hF);
    peek("full_status", 6'h01, 32'h0008_0409);
    chk("full_frozen", {31'b0, cmd_valid}, 32'h0);
    wr(6'h01, 32'h0000_0400, 4'hF);
    peek("ovf_w1c", 6'h01, 32'h0008_0009);

    // Full FIFO: push with simultaneous pop is accepted
    cmd_ready = 1'b0;
    wr(6'h00, 32'h1, 4'hF);
    #1;
    chk("full_head", {16'b0, cmd_wdata}, 32'h0000);
    cmd_ready = 1'b1;
    wr(6'h03, 32'h0000_00AA, 4'hF);
    cmd_ready = 1'b0;
    peek("push_pop_full", 6'h01, 32'h0008_0009);
    chk("head_after_pop", {16'b0, cmd_wdata}, 32'h0001);
    wr(6'h00, 32'h3, 4'hF);
    peek("flush_status", 6'h01, 32'h0000_000A);
    chk("flush_valid", {31'b0, cmd_valid}, 32'h0);

    // Response FIFO overflow, ordered pops, underflow
    for (int i = 0; i < 5; i++) begin
      rsp_valid = 1'b1; rsp_data = 16'h0011 + 16'(i);
      @(negedge axi_clk);
    end
    rsp_valid = 1'b0;
    peek("rsp_full", 6'h01, 32'h0400_1006);
    for (int i = 0; i < 4; i++) rd_chk($sformatf("rsp_pop%0d", i), 6'h04, 1'b1, 32'h11 + i);
    rd_chk("rsp_underflow_data", 6'h04, 1'b1, 32'hDEAD_BEEF);
    peek("rsp_stickies", 6'h01, 32'h0000_180A);
    wr(6'h01, 32'h0000_1C00, 4'hF);
    peek("rsp_w1c", 6'h01, 32'h0000_000A);

    // Interrupt on missed_ack and set-wins W1C
    wr(6'h05, 32'h0000_0200, 4'hF);
    chk("irq_idle", {31'b0, irq}, 32'h0);
    missed_ack = 1'b1;
    @(negedge axi_clk);
    missed_ack = 1'b0;
    #1;
    chk("irq_latency", {31'b0, irq}, 32'h0);
    peek("nack_sticky", 6'h01, 32'h0000_020A);
    @(negedge axi_clk);
    #1;
    chk("irq_set", {31'b0, irq}, 32'h1);
    missed_ack = 1'b1;
    wr(6'h01, 32'h0000_0200, 4'hF);
    missed_ack = 1'b0;
    peek("set_wins", 6'h01, 32'h0000_020A);
    wr(6'h01, 32'h0000_0200, 4'hF);
    peek("w1c_clear", 6'h01, 32'h0000_000A);
    @(negedge axi_clk);
    #1;
    chk("irq_clear", {31'b0, irq}, 32'h0);
    wr(6'h05, 32'h0, 4'hF);

    // Controller reset request and init_done release
    wr(6'h00, 32'h8000_0001, 4'hF);
    peek("ctrl_rst_read", 6'h00, 32'h8000_0001);
    chk("ctrl_rst_out", {31'b0, controller_reset}, 32'h1);
    wr(6'h03, 32'h0000_1234, 4'hF);
    #1;
    chk("ctrl_rst_blocks", {31'b0, cmd_valid}, 32'h0);
    controller_busy = 1'b1; codec_init_done = 1'b1;
    @(negedge axi_clk);
    codec_init_done = 1'b0;
    #1;
    chk("init_release", {31'b0, controller_reset}, 32'h0);
    peek("init_status", 6'h01, 32'h0001_0118);
    chk("resume_valid", {31'b0, cmd_valid}, 32'h1);
    chk("resume_wdata", {16'b0, cmd_wdata}, 32'h1234);
    codec_init_done = 1'b1;
    wr(6'h00, 32'h8000_0001, 4'hF);
    codec_init_done = 1'b0;
    #1;
    chk("clear_wins", {31'b0, controller_reset}, 32'h0);
    controller_busy = 1'b0;

    // Async reset in the middle of a queued sequence
    wr(6'h03, 32'h0000_0001, 4'hF);
    wr(6'h03, 32'h0000_0002, 4'hF);
    peek("pre_rst_status", 6'h01, 32'h0003_0108);
    wr(6'h05, 32'h0000_0100, 4'hF);
    @(negedge axi_clk);
    #1;
    chk("pre_rst_irq", {31'b0, irq}, 32'h1);
    #2 axi_reset = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, cmd_valid}, 32'h0);
    chk("mid_rst_irq", {31'b0, irq}, 32'h0);
    peek("mid_rst_status", 6'h01, 32'h0000_000A);
    peek("mid_rst_ctrl", 6'h00, 32'h0000_0000);
    peek("mid_rst_cmd_addr", 6'h02, 32'h0000_0000);
    @(negedge axi_clk);
    axi_reset = 1'b1;
    peek("post_rst_irq_en", 6'h05, 32'h0000_0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
